// File: rtl/nanorv32_trace_pkg.sv
// Shared definitions for the nanorv32 retire-trace formatter.
//
// Contents:
//   - Line geometry: LINE_LEN and the character index of each field.
//   - ASCII constants SP, EQ, LF.
//   - trace_entry_t: one captured retire event {pc, rd, we, data}, 70 bits.
//   - fmt_state_e: formatter FSM states.
//   - hex_nibble_to_ascii(): 4-bit value to a lowercase hex digit.
//   - reg_name(): 4-character register name, left-justified and space-padded.
//     The first character sits in bits [31:24].

package nanorv32_trace_pkg;

    localparam int unsigned LINE_LEN = 23;

    // Character positions within a rendered line
    localparam logic [4:0] IDX_PC   = 5'd0;
    localparam logic [4:0] IDX_SEP  = 5'd8;
    localparam logic [4:0] IDX_NAME = 5'd9;
    localparam logic [4:0] IDX_EQ   = 5'd13;
    localparam logic [4:0] IDX_DATA = 5'd14;
    localparam logic [4:0] IDX_LF   = 5'd22;

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] EQ = 8'h3D;
    localparam logic [7:0] LF = 8'h0A;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } trace_entry_t;

    localparam int unsigned ENTRY_W = $bits(trace_entry_t);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StEmit = 1'b1
    } fmt_state_e;

    function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        // 8'h57 + 10 == 'a'
        if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
        else             ch = 8'h57 + {4'h0, nib};
        return ch;
    endfunction

    function automatic logic [31:0] reg_name(input logic [4:0] idx, input logic abi);
        logic [31:0] name;
        logic [4:0]  tens;
        logic [4:0]  ones;
        tens = idx / 5'd10;
        ones = idx % 5'd10;
        name = {4{SP}};
        if (abi) begin
            unique case (idx)
                5'd0:  name = "zero";
                5'd1:  name = "ra  ";
                5'd2:  name = "sp  ";
                5'd3:  name = "gp  ";
                5'd4:  name = "tp  ";
                5'd5:  name = "t0  ";
                5'd6:  name = "t1  ";
                5'd7:  name = "t2  ";
                5'd8:  name = "s0  ";
                5'd9:  name = "s1  ";
                5'd10: name = "a0  ";
                5'd11: name = "a1  ";
                5'd12: name = "a2  ";
                5'd13: name = "a3  ";
                5'd14: name = "a4  ";
                5'd15: name = "a5  ";
                5'd16: name = "a6  ";
                5'd17: name = "a7  ";
                5'd18: name = "s2  ";
                5'd19: name = "s3  ";
                5'd20: name = "s4  ";
                5'd21: name = "s5  ";
                5'd22: name = "s6  ";
                5'd23: name = "s7  ";
                5'd24: name = "s8  ";
                5'd25: name = "s9  ";
                5'd26: name = "s10 ";
                5'd27: name = "s11 ";
                5'd28: name = "t3  ";
                5'd29: name = "t4  ";
                5'd30: name = "t5  ";
                5'd31: name = "t6  ";
            endcase
        end else if (idx < 5'd10) begin
            name = {8'h78, 8'h30 + {3'b000, ones}, SP, SP};
        end else begin
            name = {8'h78, 8'h30 + {3'b000, tens}, 8'h30 + {3'b000, ones}, SP};
        end
        return name;
    endfunction

endpackage

// File: rtl/nanorv32_trace_fifo.sv
// Generic synchronous FIFO used to buffer retire events.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i (ignored when full unless pop_i is also taken)
//   wdata_i      write data
//   pop_i        drop the head entry (ignored when empty)
//   rdata_o      head entry, valid while !empty_o
//   full_o       DEPTH entries stored
//   empty_o      no entries stored
//   level_o      number of stored entries
//
// DEPTH must be a power of two so the pointers wrap naturally.

module nanorv32_trace_fifo #(
    parameter int unsigned WIDTH = 70,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_en, pop_en;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_en  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_en, pop_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/nanorv32_trace_fmt.sv
// Retire-trace formatter for the nanorv32 core.
//
// Captures write-back events into a FIFO and streams each one as a fixed
// 23-character ASCII line "pppppppp nnnn=dddddddd\n" over valid/ready.
// When the instruction does not write rd, the name/value part is blank.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   retire_valid     one retire event this cycle
//   retire_pc        PC of the retired instruction
//   retire_rd        destination register index
//   retire_rd_we     instruction writes rd
//   retire_rd_data   value written to rd
//   char_valid       char_data holds a byte of the current line
//   char_data        ASCII byte
//   char_ready       sink accepts the byte
//   fifo_level       events waiting in the FIFO (excludes the line being sent)
//   drop_cnt         events lost to a full FIFO, saturating

module nanorv32_trace_fmt
    import nanorv32_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ABI_NAMES = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   retire_valid,
    input  logic [31:0]            retire_pc,
    input  logic [4:0]             retire_rd,
    input  logic                   retire_rd_we,
    input  logic [31:0]            retire_rd_data,
    output logic                   char_valid,
    output logic [7:0]             char_data,
    input  logic                   char_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       drop_cnt
);

    fmt_state_e   state_q, state_d;
    trace_entry_t line_q, line_d;
    trace_entry_t push_entry, head_entry;
    logic [4:0]   idx_q, idx_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic [7:0]  cur_byte;
    logic [31:0] name;
    logic [2:0]  data_sel;
    logic [1:0]  name_sel;

    assign push_entry = '{pc: retire_pc, rd: retire_rd, we: retire_rd_we, data: retire_rd_data};
    assign push       = retire_valid && (!fifo_full || pop);

    nanorv32_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Drop counter: counts only events that could not be stored
    always_comb begin
        drop_d = drop_q;
        if (retire_valid && fifo_full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    assign drop_cnt = drop_q;

    // State, line register and character index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            line_q  <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    // Next state; the last byte's acceptance reloads straight from the FIFO
    // so consecutive lines stream without a bubble.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    line_d  = head_entry;
                    idx_d   = IDX_PC;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (char_ready) begin
                    if (idx_q != IDX_LF) begin
                        idx_d = idx_q + 5'd1;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        line_d = head_entry;
                        idx_d  = IDX_PC;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte selection from the registered line. Nibble k counted from the MSB
    // lives at bit 4*(7-k), and 7-k is ~k in three bits.
    always_comb begin
        name     = reg_name(line_q.rd, ABI_NAMES != 0);
        data_sel = 3'(idx_q - IDX_DATA);
        name_sel = 2'(idx_q - IDX_NAME);
        if (idx_q < IDX_SEP) begin
            cur_byte = hex_nibble_to_ascii(line_q.pc[{~idx_q[2:0], 2'b00} +: 4]);
        end else if (idx_q == IDX_LF) begin
            cur_byte = LF;
        end else if (!line_q.we || (idx_q == IDX_SEP)) begin
            cur_byte = SP;
        end else if (idx_q < IDX_EQ) begin
            cur_byte = name[{~name_sel, 3'b000} +: 8];
        end else if (idx_q == IDX_EQ) begin
            cur_byte = EQ;
        end else begin
            cur_byte = hex_nibble_to_ascii(line_q.data[{~data_sel, 2'b00} +: 4]);
        end
    end

    // Outputs depend only on registered state, so char_data is stable under
    // backpressure.
    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        if (state_q == StEmit) begin
            char_valid = 1'b1;
            char_data  = cur_byte;
        end
    end

endmodule

// File: tb/tb_nanorv32_trace_fmt.sv
// Directed bench for nanorv32_trace_fmt.
// dut_a: DEPTH=4, ABI names, 16-bit drop counter.
// dut_n: DEPTH=2, numeric names, 2-bit drop counter (saturates quickly).

module tb_nanorv32_trace_fmt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] r_pc = '0;
    logic [4:0]  r_rd = '0;
    logic        r_we = 1'b0;
    logic [31:0] r_data = '0;

    logic        a_rv = 1'b0, a_ready = 1'b1;
    logic        a_cv;
    logic [7:0]  a_cd;
    logic [2:0]  a_level;
    logic [15:0] a_drop;

    logic        n_rv = 1'b0, n_ready = 1'b1;
    logic        n_cv;
    logic [7:0]  n_cd;
    logic [1:0]  n_level;
    logic [1:0]  n_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] qa[$];
    int         qa_t[$];
    logic [7:0] qn[$];

    nanorv32_trace_fmt #(
        .DEPTH     (4),
        .ABI_NAMES (1),
        .CNT_W     (16)
    ) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .retire_valid   (a_rv),
        .retire_pc      (r_pc),
        .retire_rd      (r_rd),
        .retire_rd_we   (r_we),
        .retire_rd_data (r_data),
        .char_valid     (a_cv),
        .char_data      (a_cd),
        .char_ready     (a_ready),
        .fifo_level     (a_level),
        .drop_cnt       (a_drop)
    );

    nanorv32_trace_fmt #(
        .DEPTH     (2),
        .ABI_NAMES (0),
        .CNT_W     (2)
    ) dut_n (
        .clk            (clk),
        .rst_n          (rst_n),
        .retire_valid   (n_rv),
        .retire_pc      (r_pc),
        .retire_rd      (r_rd),
        .retire_rd_we   (r_we),
        .retire_rd_data (r_data),
        .char_valid     (n_cv),
        .char_data      (n_cd),
        .char_ready     (n_ready),
        .fifo_level     (n_level),
        .drop_cnt       (n_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte that will be accepted at the coming rising edge
    always @(negedge clk) begin
        if (a_cv && a_ready) begin
            qa.push_back(a_cd);
            qa_t.push_back(cyc);
        end
        if (n_cv && n_ready) qn.push_back(n_cd);
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic retire(input bit sel, input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic [31:0] d);
        @(posedge clk);
        #1;
        r_pc = pc; r_rd = rd; r_we = we; r_data = d;
        if (sel) n_rv = 1'b1;
        else     a_rv = 1'b1;
        @(posedge clk);
        #1;
        a_rv = 1'b0;
        n_rv = 1'b0;
    endtask

    // Collect 23 accepted bytes; t0/t1 are the cycle stamps of first/last (dut_a)
    task automatic get_line(input bit sel, input string tag, output logic [191:0] ln,
                            output int t0, output int t1);
        int n;
        ln = '0; t0 = 0; t1 = 0;
        for (int i = 0; i < 200; i++) begin
            n = sel ? qn.size() : qa.size();
            if (n >= 23) break;
            tick();
        end
        n = sel ? qn.size() : qa.size();
        if (n < 23) begin
            check({tag, "_timeout"}, 192'(n), 192'd23);
        end else begin
            for (int i = 0; i < 23; i++) begin
                if (sel) begin
                    ln = {ln[183:0], qn.pop_front()};
                end else begin
                    ln = {ln[183:0], qa.pop_front()};
                    t1 = qa_t.pop_front();
                    if (i == 0) t0 = t1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] ln;
        int t0, t1, u0, u1;
        bit seen;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", a_cv, 1'b0);
        check("rst_data", a_cd, 8'h00);
        check("rst_level", a_level, 3'd0);
        check("rst_drop", a_drop, 16'd0);
        check("rst_n_valid", n_cv, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic line, latency 2 cycles
        retire(1'b0, 32'h0000_0080, 5'd10, 1'b1, 32'h0000_002A);
        @(negedge clk);
        check("lat_n1_valid", a_cv, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", a_cv, 1'b1);
        check("lat_n2_byte0", a_cd, 8'h30);
        get_line(1'b0, "line_a0", ln, t0, t1);
        check("line_a0", ln, "00000080 a0  =0000002a\n");
        repeat (5) tick();
        check("line_a0_count", 192'(qa.size()), 192'd0);
        check("line_a0_idle", a_cv, 1'b0);

        // ABI names s0 / zero, and blank we=0 line
        retire(1'b0, 32'h0000_0100, 5'd8, 1'b1, 32'h1234_5678);
        get_line(1'b0, "name_s0", ln, t0, t1);
        check("name_s0", ln, "00000100 s0  =12345678\n");
        retire(1'b0, 32'h0000_0004, 5'd0, 1'b1, 32'h0);
        get_line(1'b0, "name_zero", ln, t0, t1);
        check("name_zero", ln, "00000004 zero=00000000\n");
        retire(1'b0, 32'hDEAD_BEEC, 5'd5, 1'b0, 32'hFFFF_FFFF);
        get_line(1'b0, "we0", ln, t0, t1);
        check("we0", ln, {"deadbeec", {14{8'h20}}, 8'h0A});

        // Backpressure at idx 9, then a queued second line
        repeat (3) tick();
        a_ready = 1'b0;
        retire(1'b0, 32'hCAFE_0010, 5'd1, 1'b1, 32'h0BAD_F00D);
        retire(1'b0, 32'h0000_0010, 5'd31, 1'b1, 32'h0000_0001);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_cv) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_start_valid", seen, 1'b1);
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", a_cd, 8'h72);
            check("bp_hold_valid", a_cv, 1'b1);
        end
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        get_line(1'b0, "bp_line1", ln, t0, t1);
        check("bp_line1", ln, "cafe0010 ra  =0badf00d\n");
        get_line(1'b0, "bp_line2", ln, u0, u1);
        check("bp_line2", ln, "00000010 t6  =00000001\n");
        check("no_bubble", 192'(u0), 192'(t1 + 1));

        // Overflow: 6 back-to-back retires with the sink stalled
        repeat (5) tick();
        a_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            r_pc = 32'h100 + 32'(4 * i); r_rd = 5'd2; r_we = 1'b1; r_data = 32'(i);
            a_rv = 1'b1;
            @(posedge clk);
            #1;
        end
        a_rv = 1'b0;
        @(negedge clk);
        check("ovf_level", a_level, 3'd4);
        check("ovf_drop", a_drop, 16'd1);
        // Push while full in the same cycle the line's LF pops the head
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        repeat (22) begin
            @(posedge clk);
            #1;
        end
        r_pc = 32'h200; r_rd = 5'd2; r_we = 1'b1; r_data = 32'h99;
        a_rv = 1'b1;
        @(posedge clk);
        #1;
        a_rv = 1'b0;
        @(negedge clk);
        check("full_pushpop_level", a_level, 3'd4);
        check("full_pushpop_drop", a_drop, 16'd1);
        get_line(1'b0, "ovf_line0", ln, t0, t1);
        check("ovf_line0", ln, "00000100 sp  =00000000\n");
        for (int i = 1; i < 4; i++) get_line(1'b0, "ovf_mid", ln, t0, t1);
        get_line(1'b0, "ovf_line4", ln, t0, t1);
        check("ovf_line4", ln, "00000110 sp  =00000004\n");
        get_line(1'b0, "ovf_line5", ln, t0, t1);
        check("ovf_line5", ln, "00000200 sp  =00000099\n");
        repeat (5) tick();
        check("ovf_drained", 192'(qa.size()), 192'd0);
        check("ovf_level_end", a_level, 3'd0);

        // Numeric names and drop saturation on dut_n
        retire(1'b1, 32'h0000_001C, 5'd31, 1'b1, 32'hA5A5_A5A5);
        get_line(1'b1, "num_x31", ln, t0, t1);
        check("num_x31", ln, "0000001c x31 =a5a5a5a5\n");
        retire(1'b1, 32'h0000_0020, 5'd0, 1'b1, 32'h0);
        get_line(1'b1, "num_x0", ln, t0, t1);
        check("num_x0", ln, "00000020 x0  =00000000\n");
        repeat (3) tick();
        n_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            r_pc = 32'h300 + 32'(4 * i); r_rd = 5'd3; r_we = 1'b1; r_data = 32'(i);
            n_rv = 1'b1;
            @(posedge clk);
            #1;
        end
        n_rv = 1'b0;
        @(negedge clk);
        check("sat_level", n_level, 2'd2);
        check("sat_drop", n_drop, 2'd3);

        // Reset in the middle of a line
        a_ready = 1'b1;
        retire(1'b0, 32'h1357_2468, 5'd11, 1'b1, 32'h0);
        for (int i = 0; i < 50; i++) begin
            if (qa.size() >= 5) break;
            tick();
        end
        check("mid_bytes", 192'(qa.size()), 192'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_cv, 1'b0);
        check("mid_rst_level", a_level, 3'd0);
        check("mid_rst_drop", a_drop, 16'd0);
        check("mid_rst_n_drop", n_drop, 2'd0);
        check("mid_rst_n_level", n_level, 2'd0);
        qa.delete();
        qa_t.delete();
        qn.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_no_bytes", 192'(qa.size()), 192'd0);
        check("post_rst_idle", a_cv, 1'b0);
        retire(1'b0, 32'h0000_0ABC, 5'd11, 1'b1, 32'hFEED_FACE);
        get_line(1'b0, "post_rst_line", ln, t0, t1);
        check("post_rst_line", ln, "00000abc a1  =feedface\n");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
